// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the two-wheel motor drive.
//   - drive command encodings (stop / turn right / turn left / straight)
//   - H-bridge IN1/IN2 direction codes (forward, brake, coast)
//   - drive FSM state enum
//   - ramp and direction helper functions
package motor_pkg;

  localparam logic [1:0] CMD_STOP     = 2'b00;
  localparam logic [1:0] CMD_RIGHT    = 2'b01;
  localparam logic [1:0] CMD_LEFT     = 2'b10;
  localparam logic [1:0] CMD_STRAIGHT = 2'b11;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;
  localparam logic [1:0] DIR_COAST = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10
  } state_t;

  // Move cur one step toward tgt, landing exactly on tgt when within one step.
  // Differences are only formed in the direction that cannot underflow.
  function automatic int unsigned ramp_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
    int unsigned res;
    if (cur < tgt) begin
      if ((tgt - cur) <= step) res = tgt;
      else                     res = cur + step;
    end else if (cur > tgt) begin
      if ((cur - tgt) <= step) res = tgt;
      else                     res = cur - step;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // H-bridge code for one wheel given the FSM state and whether its duty is non-zero.
  function automatic logic [1:0] dir_code(input state_t st, input logic active);
    logic [1:0] d;
    case (st)
      ST_BRAKE: d = DIR_BRAKE;
      ST_RUN:   d = active ? DIR_FWD : DIR_COAST;
      default:  d = DIR_COAST;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: one PWM channel.
//   clk, rst      : clock, asynchronous active-high reset
//   i_duty        : requested duty (0..PWM_PERIOD), sampled only at counter wrap
//   i_en_nxt      : output enable for the coming cycle (gates the pulse to 0)
//   o_pwm         : registered PWM output, high while count < latched duty
//   o_active_nxt  : latched duty will be non-zero in the coming cycle
// Every instance resets its counter to 0 together, so channels stay phase-aligned.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 1024,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_duty,
  input  logic          i_en_nxt,
  output logic          o_pwm,
  output logic          o_active_nxt
);

  localparam int            CW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_duty_act;
  logic          r_pwm;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_duty_nxt;

  // Counter wrap and wrap-only duty latch, so a period is never cut short.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_duty_nxt = r_duty_act;
    if (r_cnt == CNT_LAST) begin
      w_cnt_nxt  = '0;
      w_duty_nxt = i_duty;
    end else begin
      w_cnt_nxt  = r_cnt + CW'(1);
      w_duty_nxt = r_duty_act;
    end
  end

  // Output is registered from next-state values so it lines up with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_duty_act <= w_duty_nxt;
      r_pwm      <= i_en_nxt && (DW'(w_cnt_nxt) < w_duty_nxt);
    end
  end

  assign o_pwm        = r_pwm;
  assign o_active_nxt = (w_duty_nxt != '0);

endmodule

// File: rtl/motor_drive.sv
// motor_drive: two-wheel differential drive controller.
//   clk, rst                  : clock, asynchronous active-high reset
//   i_cmd                     : 00 stop, 01 turn right, 10 turn left, 11 straight
//   o_left_pwm, o_right_pwm   : motor enable PWM per wheel
//   o_left_dir, o_right_dir   : H-bridge IN1/IN2 (10 forward, 11 brake, 00 coast)
//   o_moving                  : high while in RUN
// A command must be stable for CMD_HOLD edges before it is acted on. Duties ramp
// toward per-wheel targets; stopping applies a timed short brake before IDLE.
module motor_drive
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 1024,
  parameter int DUTY_FAST    = 768,
  parameter int DUTY_SLOW    = 256,
  parameter int RAMP_STEP    = 32,
  parameter int RAMP_DIV     = 65536,
  parameter int CMD_HOLD     = 4,
  parameter int BRAKE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_cmd,
  output logic       o_left_pwm,
  output logic       o_right_pwm,
  output logic [1:0] o_left_dir,
  output logic [1:0] o_right_dir,
  output logic       o_moving
);

  localparam int DW  = $clog2(PWM_PERIOD + 1);
  localparam int HW  = $clog2(CMD_HOLD + 1);
  localparam int DVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int BW  = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;

  localparam logic [HW-1:0]  HOLD_MAX   = HW'(CMD_HOLD);
  localparam logic [DVW-1:0] DIV_LAST   = DVW'(RAMP_DIV - 1);
  localparam logic [BW-1:0]  BRAKE_LAST = BW'(BRAKE_CYCLES - 1);
  localparam logic [DW-1:0]  D_FAST     = DW'(DUTY_FAST);
  localparam logic [DW-1:0]  D_SLOW     = DW'(DUTY_SLOW);

  logic [1:0]     r_cmd_last;
  logic [HW-1:0]  r_hold_cnt;
  logic [1:0]     r_acc_cmd;
  logic [DVW-1:0] r_div_cnt;
  state_t         r_state;
  logic [BW-1:0]  r_brake_cnt;
  logic [DW-1:0]  r_left_cur;
  logic [DW-1:0]  r_right_cur;
  logic [1:0]     r_left_dir;
  logic [1:0]     r_right_dir;
  logic           r_moving;

  logic [HW-1:0]  w_hold_nxt;
  logic           w_tick;
  state_t         w_state_nxt;
  logic [BW-1:0]  w_brake_nxt;
  logic           w_run_nxt;
  logic [DW-1:0]  w_left_tgt;
  logic [DW-1:0]  w_right_tgt;
  logic [DW-1:0]  w_left_cur_nxt;
  logic [DW-1:0]  w_right_cur_nxt;
  logic           w_left_act_nxt;
  logic           w_right_act_nxt;

  // Count consecutive edges on which the same command was sampled.
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (i_cmd != r_cmd_last) begin
      w_hold_nxt = HW'(1);
    end else if (r_hold_cnt < HOLD_MAX) begin
      w_hold_nxt = r_hold_cnt + HW'(1);
    end else begin
      w_hold_nxt = r_hold_cnt;
    end
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  // Drive FSM; BRAKE runs to completion regardless of the accepted command.
  always_comb begin
    w_state_nxt = r_state;
    w_brake_nxt = r_brake_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_acc_cmd != CMD_STOP) w_state_nxt = ST_RUN;
        else                       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (r_acc_cmd == CMD_STOP) begin
          w_state_nxt = ST_BRAKE;
          w_brake_nxt = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_BRAKE: begin
        if (r_brake_cnt == BRAKE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_brake_nxt = '0;
        end else begin
          w_brake_nxt = r_brake_cnt + BW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_brake_nxt = '0;
      end
    endcase
  end

  assign w_run_nxt = (w_state_nxt == ST_RUN);

  // Per-wheel duty targets from the accepted command.
  always_comb begin
    w_left_tgt  = '0;
    w_right_tgt = '0;
    case (r_acc_cmd)
      CMD_STRAIGHT: begin w_left_tgt = D_FAST; w_right_tgt = D_FAST; end
      CMD_LEFT:     begin w_left_tgt = D_SLOW; w_right_tgt = D_FAST; end
      CMD_RIGHT:    begin w_left_tgt = D_FAST; w_right_tgt = D_SLOW; end
      default:      begin w_left_tgt = '0;     w_right_tgt = '0;     end
    endcase
  end

  // Ramp only while staying in RUN; leaving RUN (into BRAKE) zeroes both duties at once.
  always_comb begin
    w_left_cur_nxt  = '0;
    w_right_cur_nxt = '0;
    if ((r_state == ST_RUN) && w_run_nxt) begin
      if (w_tick) begin
        w_left_cur_nxt  = DW'(ramp_toward(32'(r_left_cur),  32'(w_left_tgt),  32'(RAMP_STEP)));
        w_right_cur_nxt = DW'(ramp_toward(32'(r_right_cur), 32'(w_right_tgt), 32'(RAMP_STEP)));
      end else begin
        w_left_cur_nxt  = r_left_cur;
        w_right_cur_nxt = r_right_cur;
      end
    end else begin
      w_left_cur_nxt  = '0;
      w_right_cur_nxt = '0;
    end
  end

  // State, filter, ramp divider and duty registers; outputs registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_last  <= 2'b00;
      r_hold_cnt  <= '0;
      r_acc_cmd   <= CMD_STOP;
      r_div_cnt   <= '0;
      r_state     <= ST_IDLE;
      r_brake_cnt <= '0;
      r_left_cur  <= '0;
      r_right_cur <= '0;
      r_left_dir  <= DIR_COAST;
      r_right_dir <= DIR_COAST;
      r_moving    <= 1'b0;
    end else begin
      r_cmd_last  <= i_cmd;
      r_hold_cnt  <= w_hold_nxt;
      if (w_hold_nxt == HOLD_MAX) r_acc_cmd <= i_cmd;
      r_div_cnt   <= w_tick ? '0 : (r_div_cnt + DVW'(1));
      r_state     <= w_state_nxt;
      r_brake_cnt <= w_brake_nxt;
      r_left_cur  <= w_left_cur_nxt;
      r_right_cur <= w_right_cur_nxt;
      r_left_dir  <= dir_code(w_state_nxt, w_left_act_nxt);
      r_right_dir <= dir_code(w_state_nxt, w_right_act_nxt);
      r_moving    <= w_run_nxt;
    end
  end

  pwm_gen #(.PWM_PERIOD(PWM_PERIOD), .DW(DW)) u_pwm_left (
    .clk          (clk),
    .rst          (rst),
    .i_duty       (r_left_cur),
    .i_en_nxt     (w_run_nxt),
    .o_pwm        (o_left_pwm),
    .o_active_nxt (w_left_act_nxt)
  );

  pwm_gen #(.PWM_PERIOD(PWM_PERIOD), .DW(DW)) u_pwm_right (
    .clk          (clk),
    .rst          (rst),
    .i_duty       (r_right_cur),
    .i_en_nxt     (w_run_nxt),
    .o_pwm        (o_right_pwm),
    .o_active_nxt (w_right_act_nxt)
  );

  assign o_left_dir  = r_left_dir;
  assign o_right_dir = r_right_dir;
  assign o_moving    = r_moving;

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: two instances (DUTY_FAST=12 and the DUTY_FAST=16 variant)
// share one command/reset stream and are compared every cycle against a
// behavioural model, plus directed literal checks of latency, duty, and brake length.
module tb_motor_drive;

  localparam int P   = 16;
  localparam int DF  = 12;
  localparam int DF2 = 16;
  localparam int DS  = 4;
  localparam int RS  = 4;
  localparam int RD  = 8;
  localparam int CH  = 4;
  localparam int BC  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic       lp0, rp0, mv0, lp1, rp1, mv1;
  logic [1:0] ld0, rd0, ld1, rd1;

  int n_checks = 0;
  int n_fails  = 0;
  bit cmp_en   = 1'b0;

  motor_drive #(.PWM_PERIOD(P), .DUTY_FAST(DF), .DUTY_SLOW(DS), .RAMP_STEP(RS),
                .RAMP_DIV(RD), .CMD_HOLD(CH), .BRAKE_CYCLES(BC)) dut0 (
    .clk(clk), .rst(rst), .i_cmd(cmd),
    .o_left_pwm(lp0), .o_right_pwm(rp0), .o_left_dir(ld0), .o_right_dir(rd0), .o_moving(mv0));

  motor_drive #(.PWM_PERIOD(P), .DUTY_FAST(DF2), .DUTY_SLOW(DS), .RAMP_STEP(RS),
                .RAMP_DIV(RD), .CMD_HOLD(CH), .BRAKE_CYCLES(BC)) dut1 (
    .clk(clk), .rst(rst), .i_cmd(cmd),
    .o_left_pwm(lp1), .o_right_pwm(rp1), .o_left_dir(ld1), .o_right_dir(rd1), .o_moving(mv1));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 brake. m_n counts clock edges since reset release,
  // so PWM phase is m_n mod P and ramp ticks land where m_n mod RD == RD-1.
  int         m_n, m_mode, m_acc, m_brake_left;
  int         m_cur [2][2];
  int         m_act [2][2];
  logic [1:0] m_hist [$];

  task automatic model_reset();
    m_n = 0; m_mode = 0; m_acc = 0; m_brake_left = 0;
    m_hist.delete();
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 2; w++) begin
        m_cur[i][w] = 0;
        m_act[i][w] = 0;
      end
  endtask

  function automatic int target(input int inst, input int wheel, input int acc);
    int fast;
    fast = (inst == 1) ? DF2 : DF;
    case (acc)
      3:       return fast;
      2:       return (wheel == 0) ? DS : fast;
      1:       return (wheel == 0) ? fast : DS;
      default: return 0;
    endcase
  endfunction

  function automatic int approach(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > RS) d = RS;
    else if (d < -RS) d = -RS;
    return cur + d;
  endfunction

  task automatic model_step(input logic [1:0] c);
    int old_mode, old_acc;
    bit tick, wrap, same;
    old_mode = m_mode;
    old_acc  = m_acc;
    tick = ((m_n % RD) == RD - 1);
    wrap = ((m_n % P) == P - 1);
    m_hist.push_back(c);
    if (m_hist.size() > CH) void'(m_hist.pop_front());
    if (m_hist.size() == CH) begin
      same = 1'b1;
      foreach (m_hist[k]) if (m_hist[k] != c) same = 1'b0;
      if (same) m_acc = int'(c);
    end
    case (old_mode)
      0: if (old_acc != 0) m_mode = 1;
      1: if (old_acc == 0) begin m_mode = 2; m_brake_left = BC; end
      default: begin
        m_brake_left--;
        if (m_brake_left == 0) m_mode = 0;
      end
    endcase
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 2; w++) begin
        if (wrap) m_act[i][w] = m_cur[i][w];
        if (old_mode == 1 && m_mode == 1) begin
          if (tick) m_cur[i][w] = approach(m_cur[i][w], target(i, w, old_acc));
        end else begin
          m_cur[i][w] = 0;
        end
      end
    m_n++;
  endtask

  function automatic int exp_pwm(input int i, input int w);
    return (m_mode == 1 && (m_n % P) < m_act[i][w]) ? 1 : 0;
  endfunction

  function automatic int exp_dir(input int i, input int w);
    if (m_mode == 2) return 3;
    if (m_mode == 1 && m_act[i][w] > 0) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dut0 left_pwm",  int'(lp0), exp_pwm(0, 0));
      chk("dut0 right_pwm", int'(rp0), exp_pwm(0, 1));
      chk("dut0 left_dir",  int'(ld0), exp_dir(0, 0));
      chk("dut0 right_dir", int'(rd0), exp_dir(0, 1));
      chk("dut0 moving",    int'(mv0), (m_mode == 1) ? 1 : 0);
      chk("dut1 left_pwm",  int'(lp1), exp_pwm(1, 0));
      chk("dut1 right_pwm", int'(rp1), exp_pwm(1, 1));
      chk("dut1 left_dir",  int'(ld1), exp_dir(1, 0));
      chk("dut1 right_dir", int'(rd1), exp_dir(1, 1));
      chk("dut1 moving",    int'(mv1), (m_mode == 1) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic [1:0] c);
    cmd = c;
    @(posedge clk);
    if (!rst) model_step(c);
    @(negedge clk);
  endtask

  task automatic run_count(input logic [1:0] c, input int ncyc,
                           output int l0, output int r0, output int l1, output int r1);
    l0 = 0; r0 = 0; l1 = 0; r1 = 0;
    repeat (ncyc) begin
      cycle(c);
      l0 += int'(lp0); r0 += int'(rp0); l1 += int'(lp1); r1 += int'(rp1);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    @(posedge clk);
    if (!rst) model_step(cmd);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async rst left_pwm",  int'(lp0), 0);
    chk("async rst right_pwm", int'(rp0), 0);
    chk("async rst left_dir",  int'(ld0), 0);
    chk("async rst right_dir", int'(rd0), 0);
    chk("async rst moving",    int'(mv0), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int a, b, c2, d, brk, len;
    logic [1:0] rc;

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset moving",   int'(mv0), 0);
    chk("reset left_dir", int'(ld0), 0);
    rst = 1'b0;

    // Acceptance after 4 stable edges, RUN one edge later.
    repeat (4) cycle(2'b11);
    chk("moving before hold complete", int'(mv0), 0);
    cycle(2'b11);
    chk("moving after hold", int'(mv0), 1);

    // Steady straight run.
    repeat (200) cycle(2'b11);
    run_count(2'b11, P, a, b, c2, d);
    chk("straight left highs",      a,  12);
    chk("straight right highs",     b,  12);
    chk("full duty left highs",     c2, 16);
    chk("full duty right highs",    d,  16);
    chk("straight left dir",        int'(ld0), 2);

    // Three-cycle glitch must not be accepted.
    repeat (3) cycle(2'b10);
    repeat (60) cycle(2'b11);
    run_count(2'b11, P, a, b, c2, d);
    chk("post glitch left highs",   a, 12);
    chk("post glitch right highs",  b, 12);

    // Left turn: left wheel slows to DUTY_SLOW, right stays fast.
    repeat (100) cycle(2'b10);
    run_count(2'b10, P, a, b, c2, d);
    chk("turn left inner highs",    a,  4);
    chk("turn left outer highs",    b,  12);
    chk("turn left variant outer",  d,  16);

    // Stop: brake for exactly BC cycles while cmd=11 is ignored.
    repeat (5) cycle(2'b00);
    chk("brake left dir",  int'(ld0), 3);
    chk("brake right pwm", int'(rp0), 0);
    brk = 1;
    repeat (20) begin
      cycle(2'b11);
      if (ld0 == 2'b11) brk++;
    end
    chk("brake length",           brk, 20);
    chk("idle after brake moving", int'(mv0), 0);
    chk("idle after brake dir",    int'(ld0), 0);
    cycle(2'b11);
    chk("run after brake expiry",  int'(mv0), 1);

    // Stop and idle: zero duty yields no pulses.
    repeat (40) cycle(2'b00);
    run_count(2'b00, P, a, b, c2, d);
    chk("idle left highs",          a,  0);
    chk("idle variant left highs",  c2, 0);

    // Reset mid-run, then a full hold is needed again.
    repeat (100) cycle(2'b11);
    pulse_reset();
    repeat (4) cycle(2'b11);
    chk("restart before hold", int'(mv0), 0);
    cycle(2'b11);
    chk("restart after hold",  int'(mv0), 1);

    // Randomized commands with short glitches, long holds and occasional resets.
    for (int s = 0; s < 80; s++) begin
      rc  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 19) == 0) pulse_reset();
      repeat (len) cycle(rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
